// File: rtl/vdp18_spr_slot_ctrl.sv
// rtl/vdp18_spr_slot_ctrl.sv - VDP18 per-scanline sprite slot sequencer
//
// Purpose: holds up to four sprite descriptors loaded during horizontal
// blanking, then serialises each pattern against the pixel counter. It drives
// the spr0..spr3 colour inputs of the colour mux (slot 0 = highest priority)
// and flags sprite collisions.
//
// Optional feature macro: VDP18_SPR_COLL_EN
//   defined   -> sticky collision flag with clear input
//   undefined -> coll_o tied low, coll_clr_i ignored, no collision logic
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   clk_en_5m37_i           pixel clock enable; all state advances on it
//   line_start_i            start-of-line pulse (qualified by the enable)
//   hor_active_i            horizontal active display window
//   reg_size_i, reg_mag_i   8/16-pixel sprites, 2x magnification
//   slot_load_i, slot_idx_i descriptor load strobe (sampled every clk_i edge)
//   slot_x_i/col_i/pat_i    descriptor contents
//   sprN_col_o              registered per-slot pixel colour, 0 = transparent
//   coll_o, coll_clr_i      sticky collision flag and its clear
//   busy_o                  any slot ARMED or SHIFT
module vdp18_spr_slot_ctrl #(
  parameter int num_px_g = 256,
  parameter int x_w_g    = 9
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clk_en_5m37_i,
  input  logic             line_start_i,
  input  logic             hor_active_i,
  input  logic             reg_size_i,
  input  logic             reg_mag_i,
  input  logic             slot_load_i,
  input  logic [1:0]       slot_idx_i,
  input  logic [x_w_g-1:0] slot_x_i,
  input  logic [3:0]       slot_col_i,
  input  logic [15:0]      slot_pat_i,
  output logic [3:0]       spr0_col_o,
  output logic [3:0]       spr1_col_o,
  output logic [3:0]       spr2_col_o,
  output logic [3:0]       spr3_col_o,
  output logic             coll_o,
  input  logic             coll_clr_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_SHIFT, ST_DONE} slot_st_t;

  localparam logic [x_w_g-1:0] num_px_c = x_w_g'(num_px_g);

  logic [x_w_g-1:0] px_q, px_d;
  slot_st_t         st_q  [4];
  slot_st_t         st_d  [4];
  logic [x_w_g-1:0] x_q   [4];
  logic [x_w_g-1:0] x_d   [4];
  logic [3:0]       col_q [4];
  logic [3:0]       col_d [4];
  logic [15:0]      pat_q [4];
  logic [15:0]      pat_d [4];
  logic [4:0]       cnt_q [4];
  logic [4:0]       cnt_d [4];
  logic [3:0]       out_q [4];
  logic [3:0]       out_d [4];
  logic             busy_q, busy_d;

  logic [3:0] pix;       // per-slot pattern bit emitted on this enable
  logic [4:0] last_idx;  // index of the final pixel: 7, 15 or 31
  logic [3:0] bit_idx;
  logic       step;      // enable inside the active window
  logic       vis;       // step on a pixel that is actually displayed

  always_comb begin
    px_d     = px_q;
    pix      = '0;
    busy_d   = 1'b0;
    bit_idx  = '0;
    step     = clk_en_5m37_i & hor_active_i;
    vis      = step & (px_q < num_px_c);
    last_idx = {reg_size_i & reg_mag_i, reg_size_i | reg_mag_i, 3'b111};

    if (clk_en_5m37_i) begin
      if (line_start_i) px_d = '0;
      else if (vis)     px_d = px_q + 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      st_d[i]  = st_q[i];
      x_d[i]   = x_q[i];
      col_d[i] = col_q[i];
      pat_d[i] = pat_q[i];
      cnt_d[i] = cnt_q[i];
      out_d[i] = out_q[i];
      // With magnification each pattern bit covers two pixels.
      bit_idx  = reg_mag_i ? cnt_q[i][4:1] : cnt_q[i][3:0];

      if (clk_en_5m37_i) begin
        if (line_start_i) begin
          st_d[i] = ST_IDLE;
        end else begin
          case (st_q[i])
            ST_ARMED: begin
              // The trigger enable already emits the first pixel so the
              // output lags the pixel counter by exactly one enable.
              if (vis && (px_q == x_q[i])) begin
                pix[i]   = pat_q[i][15];
                st_d[i]  = ST_SHIFT;
                cnt_d[i] = 5'd1;
              end
            end
            ST_SHIFT: begin
              if (step) begin
                // Past the last active pixel the shift keeps running but
                // nothing is shown.
                pix[i] = vis & pat_q[i][4'd15 - bit_idx];
                if (cnt_q[i] == last_idx) st_d[i] = ST_DONE;
                else                      cnt_d[i] = cnt_q[i] + 5'd1;
              end
            end
            default: ;
          endcase
        end
      end

      // Load wins over line start and aborts any shift in progress.
      if (slot_load_i && (slot_idx_i == 2'(i))) begin
        st_d[i]  = ST_ARMED;
        x_d[i]   = slot_x_i;
        col_d[i] = slot_col_i;
        pat_d[i] = slot_pat_i;
        cnt_d[i] = '0;
        pix[i]   = 1'b0;
      end

      if (clk_en_5m37_i) out_d[i] = pix[i] ? col_q[i] : 4'h0;

      busy_d = busy_d | (st_d[i] == ST_ARMED) | (st_d[i] == ST_SHIFT);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      px_q   <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= ST_IDLE;
        x_q[i]   <= '0;
        col_q[i] <= '0;
        pat_q[i] <= '0;
        cnt_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      px_q   <= px_d;
      busy_q <= busy_d;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        x_q[i]   <= x_d[i];
        col_q[i] <= col_d[i];
        pat_q[i] <= pat_d[i];
        cnt_q[i] <= cnt_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  assign spr0_col_o = out_q[0];
  assign spr1_col_o = out_q[1];
  assign spr2_col_o = out_q[2];
  assign spr3_col_o = out_q[3];
  assign busy_o     = busy_q;

`ifdef VDP18_SPR_COLL_EN
  logic coll_q, coll_d, coll_hit;

  always_comb begin
    // Two or more opaque slot pixels on the same enable.
    coll_hit = (pix[0] & pix[1]) | (pix[0] & pix[2]) | (pix[0] & pix[3]) |
               (pix[1] & pix[2]) | (pix[1] & pix[3]) | (pix[2] & pix[3]);
    coll_d = coll_q;
    if (coll_clr_i)                   coll_d = 1'b0;
    if (clk_en_5m37_i && coll_hit)    coll_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) coll_q <= 1'b0;
    else            coll_q <= coll_d;
  end

  assign coll_o = coll_q;
`else
  logic unused_coll_clr;
  assign unused_coll_clr = coll_clr_i;
  assign coll_o          = 1'b0;
`endif

endmodule

// File: tb/tb_vdp18_spr_slot_ctrl.sv
// tb/tb_vdp18_spr_slot_ctrl.sv - self-checking bench for vdp18_spr_slot_ctrl
module tb_vdp18_spr_slot_ctrl;

  localparam int NPX = 256;
`ifdef VDP18_SPR_COLL_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0, ls = 1'b0, ha = 1'b0, size = 1'b0, mag = 1'b0;
  logic        ld = 1'b0, clr = 1'b0;
  logic [1:0]  idx = '0;
  logic [8:0]  sx = '0;
  logic [3:0]  scol = '0;
  logic [15:0] spat = '0;
  logic [3:0]  s0, s1, s2, s3;
  logic        coll, busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vdp18_spr_slot_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n), .clk_en_5m37_i(en), .line_start_i(ls),
    .hor_active_i(ha), .reg_size_i(size), .reg_mag_i(mag), .slot_load_i(ld),
    .slot_idx_i(idx), .slot_x_i(sx), .slot_col_i(scol), .slot_pat_i(spat),
    .spr0_col_o(s0), .spr1_col_o(s1), .spr2_col_o(s2), .spr3_col_o(s3),
    .coll_o(coll), .coll_clr_i(clr), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] spr(input int i);
    case (i)
      0: return s0;
      1: return s1;
      2: return s2;
      default: return s3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel enable; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic h, input logic l);
    en = 1'b1; ha = h; ls = l;
    tick();
    en = 1'b0; ls = 1'b0;
  endtask

  task automatic load(input int i, input int x, input logic [3:0] c, input logic [15:0] p);
    ld = 1'b1; idx = 2'(i); sx = 9'(x); scol = c; spat = p;
    tick();
    ld = 1'b0;
  endtask

  task automatic start_line();
    step(1'b0, 1'b1);
  endtask

  // ---------------- behavioural reference model ----------------
  // Each slot is a "has descriptor" flag plus an offset counting shown pixels.
  bit          m_ld[4], m_started[4];
  int          m_off[4], m_px;
  logic [8:0]  m_x[4];
  logic [3:0]  m_col[4], m_out[4];
  logic [15:0] m_pat[4];
  bit          m_coll, m_busy;

  function automatic void model_reset();
    m_px = 0; m_coll = 0; m_busy = 0;
    for (int i = 0; i < 4; i++) begin
      m_ld[i] = 0; m_started[i] = 0; m_off[i] = 0; m_out[i] = '0;
      m_x[i] = '0; m_col[i] = '0; m_pat[i] = '0;
    end
  endfunction

  function automatic void model_step();
    int  n   = (size ? 16 : 8) * (mag ? 2 : 1);
    int  div = mag ? 2 : 1;
    bit  pix[4];
    int  hits = 0;
    for (int i = 0; i < 4; i++) pix[i] = 0;
    if (en) begin
      if (ls) begin
        m_px = 0;
        for (int i = 0; i < 4; i++) m_ld[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (m_ld[i] && !m_started[i]) begin
            if (ha && m_px < NPX && m_px == int'(m_x[i])) begin
              m_started[i] = 1; pix[i] = m_pat[i][15]; m_off[i] = 1;
            end
          end else if (m_ld[i] && m_off[i] < n && ha) begin
            pix[i] = (m_px < NPX) && m_pat[i][15 - m_off[i] / div];
            m_off[i]++;
          end
        end
        if (ha && m_px < NPX) m_px++;
      end
    end
    if (ld) begin
      m_ld[idx] = 1; m_started[idx] = 0; m_off[idx] = 0;
      m_x[idx] = sx; m_col[idx] = scol; m_pat[idx] = spat; pix[idx] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (en) m_out[i] = pix[i] ? m_col[i] : 4'h0;
      hits += pix[i];
    end
    if (clr) m_coll = 0;
    if (en && hits >= 2) m_coll = 1;
    m_busy = 0;
    for (int i = 0; i < 4; i++)
      if (m_ld[i] && (!m_started[i] || m_off[i] < n)) m_busy = 1;
  endfunction

  typedef struct {
    int          slot;
    int          x;
    logic [3:0]  col;
    logic [15:0] pat;
    logic        sz;
    logic        mg;
    int          probe;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit seen;

    // basic 8-pixel sprite, pattern A5
    for (int p = 9; p <= 18; p++) begin
      logic [9:0] shown = 10'b0101001010;  // pixels 18..9, LSB = pixel 9
      tbl.push_back('{0, 10, 4'hF, 16'hA500, 1'b0, 1'b0, p, shown[p-9] ? 4'hF : 4'h0});
    end
    // magnified 16-pixel sprite: exactly 32 pixels from 100
    tbl.push_back('{2, 100, 4'h6, 16'hFFFF, 1'b1, 1'b1,  99, 4'h0});
    tbl.push_back('{2, 100, 4'h6, 16'hFFFF, 1'b1, 1'b1, 100, 4'h6});
    tbl.push_back('{2, 100, 4'h6, 16'hFFFF, 1'b1, 1'b1, 131, 4'h6});
    tbl.push_back('{2, 100, 4'h6, 16'hFFFF, 1'b1, 1'b1, 132, 4'h0});
    // magnified 8-pixel: each bit covers two pixels
    tbl.push_back('{3, 20, 4'h9, 16'hC000, 1'b0, 1'b1, 23, 4'h9});
    tbl.push_back('{3, 20, 4'h9, 16'hC000, 1'b0, 1'b1, 24, 4'h0});
    // right edge: only pixel 255 shows
    tbl.push_back('{1, 255, 4'h5, 16'hFFFF, 1'b1, 1'b0, 255, 4'h5});
    tbl.push_back('{1, 255, 4'h5, 16'hFFFF, 1'b1, 1'b0, 256, 4'h0});
    // left edge
    tbl.push_back('{0, 0, 4'h1, 16'h8000, 1'b0, 1'b0, 0, 4'h1});
    tbl.push_back('{0, 0, 4'h1, 16'h8000, 1'b0, 1'b0, 1, 4'h0});

    // ---------------- reset state ----------------
    tick(); tick();
    for (int i = 0; i < 4; i++) chk($sformatf("reset_spr%0d", i), spr(i), 0);
    chk("reset_coll", coll, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // ---------------- table-driven vectors ----------------
    foreach (tbl[r]) begin
      size = tbl[r].sz; mag = tbl[r].mg;
      start_line();
      load(tbl[r].slot, tbl[r].x, tbl[r].col, tbl[r].pat);
      repeat (tbl[r].probe + 1) step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("vec%0d_px%0d_spr%0d", r, tbl[r].probe, i), spr(i),
            (i == tbl[r].slot) ? tbl[r].exp : 4'h0);
    end

    // ---------------- mid-line reset while slot 1 shifts ----------------
    size = 1'b0; mag = 1'b0;
    start_line();
    load(1, 20, 4'h3, 16'hFF00);
    repeat (23) step(1'b1, 1'b0);
    chk("pre_reset_spr1", s1, 4'h3);
    reset_n = 1'b0;
    #1;
    chk("async_reset_spr1", s1, 0);
    chk("async_reset_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      step(1'b1, 1'b0);
      if (s1 != 0 || busy) seen = 1;
    end
    chk("post_reset_slot1_idle", seen, 0);

    // ---------------- collision ----------------
    start_line();
    load(0, 50, 4'h1, 16'h8000);
    load(3, 50, 4'h2, 16'h8000);
    repeat (50) step(1'b1, 1'b0);
    chk("coll_before", coll, 0);
    step(1'b1, 1'b0);
    chk("coll_spr0", s0, 4'h1);
    chk("coll_spr3", s3, 4'h2);
    chk("coll_set", coll, COLL_ON);
    repeat (3) step(1'b1, 1'b0);
    chk("coll_sticky", coll, COLL_ON);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("coll_cleared", coll, 0);

    // ---------------- x beyond line, saturation ----------------
    start_line();
    load(0, 300, 4'h2, 16'hFFFF);
    seen = 0;
    repeat (300) begin
      step(1'b1, 1'b0);
      if (s0 != 0) seen = 1;
    end
    chk("x300_never_shown", seen, 0);
    chk("x300_busy", busy, 1);
    load(1, 0, 4'h7, 16'h8000);  // would fire if the counter wrapped
    seen = 0;
    repeat (5) begin
      step(1'b1, 1'b0);
      if (s1 != 0) seen = 1;
    end
    chk("px_saturates", seen, 0);
    start_line();
    chk("line_start_idles", busy, 0);

    // ---------------- line_start and load on the same enable ----------------
    start_line();
    repeat (10) step(1'b1, 1'b0);
    load(0, 5, 4'h4, 16'hFF00);
    load(2, 5, 4'h4, 16'hFF00);
    en = 1'b1; ls = 1'b1; ha = 1'b0;
    ld = 1'b1; idx = 2'd1; sx = 9'd8; scol = 4'h3; spat = 16'hFF00;
    tick();
    en = 1'b0; ls = 1'b0; ld = 1'b0;
    chk("same_en_busy", busy, 1);
    repeat (6) step(1'b1, 1'b0);
    chk("same_en_slot0_idle", s0, 0);
    chk("same_en_slot2_idle", s2, 0);
    repeat (3) step(1'b1, 1'b0);
    chk("same_en_slot1_shows", s1, 4'h3);
    repeat (11) step(1'b1, 1'b0);
    chk("same_en_all_done", busy, 0);

    // ---------------- randomized against the model ----------------
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    model_reset();
    for (int line = 0; line < 6; line++) begin
      size = 1'($urandom_range(0, 1));
      mag  = 1'($urandom_range(0, 1));
      for (int c = 0; c < 380; c++) begin
        en   = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        ls   = (c == 0);
        ha   = (c >= 12);
        ld   = (c < 12) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
        idx  = 2'($urandom_range(0, 3));
        sx   = 9'($urandom_range(0, 300));
        scol = 4'($urandom_range(0, 15));
        spat = 16'($urandom);
        clr  = ($urandom_range(0, 29) == 0);
        model_step();
        tick();
        for (int i = 0; i < 4; i++)
          chk($sformatf("rnd_l%0d_c%0d_spr%0d", line, c, i), spr(i), m_out[i]);
        chk($sformatf("rnd_l%0d_c%0d_coll", line, c), coll, COLL_ON & m_coll);
        chk($sformatf("rnd_l%0d_c%0d_busy", line, c), busy, m_busy);
      end
    end
    en = 1'b0; ls = 1'b0; ld = 1'b0; clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
